// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data with priority, starvation guard and timeout
module mem_port_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int TIMEOUT = 15,
    parameter int STARVE_LIM = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_valid,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_valid,
    output logic          mem_enable,
    output logic          mem_r_w,
    output logic [AW-1:0] mem_address,
    output logic [DW-1:0] mem_input,
    input  logic [DW-1:0] mem_output,
    input  logic          mem_ready,
    output logic          pipe_stall,
    output logic          timeout_err
);
    localparam logic [1:0] IDLE = 2'd0, BUSY_IF = 2'd1, BUSY_D = 2'd2;
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);
    localparam logic [2:0] SLIM = 3'(STARVE_LIM);
    logic [1:0] state;
    logic [7:0] wait_cnt;
    logic [2:0] starve_cnt;
    logic if_r, d_r, grant_d, grant_if;
    // A requester seeing its valid this cycle still holds a stale request
    always_comb begin
        if_r = if_req & ~if_valid;
        d_r = d_req & ~d_valid;
        grant_d = d_r & (~if_r | (starve_cnt < SLIM));
        grant_if = if_r & ~grant_d;
    end
    assign pipe_stall = (if_req & ~if_valid) | (d_req & ~d_valid);
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            wait_cnt <= '0;
            starve_cnt <= '0;
            if_rdata <= '0;
            if_valid <= 1'b0;
            d_rdata <= '0;
            d_valid <= 1'b0;
            mem_enable <= 1'b0;
            mem_r_w <= 1'b0;
            mem_address <= '0;
            mem_input <= '0;
            timeout_err <= 1'b0;
        end else begin
            if_valid <= 1'b0;
            d_valid <= 1'b0;
            if (state == IDLE) begin
                if (grant_d | grant_if) begin
                    state <= grant_d ? BUSY_D : BUSY_IF;
                    mem_enable <= 1'b1;
                    mem_address <= grant_d ? d_addr : if_addr;
                    mem_r_w <= grant_d & d_we;
                    mem_input <= grant_d ? d_wdata : '0;
                    wait_cnt <= '0;
                    starve_cnt <= grant_if ? '0 : (if_r ? starve_cnt + 3'd1 : starve_cnt);
                end
            end else if (mem_ready || wait_cnt == WAIT_LAST) begin
                state <= IDLE;
                mem_enable <= 1'b0;
                timeout_err <= timeout_err | ~mem_ready;
                if (state == BUSY_IF) begin
                    if_valid <= 1'b1;
                    if_rdata <= mem_ready ? mem_output : '0;
                end else begin
                    d_valid <= 1'b1;
                    // completed stores leave d_rdata alone; aborts always zero it
                    if (!mem_r_w || !mem_ready)
                        d_rdata <= mem_ready ? mem_output : '0;
                end
            end else begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: vector table for basic transactions plus sequences for arbitration, timeout and reset
module tb_mem_port_arbiter;
    logic clk = 1'b0, reset = 1'b0, if_req = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_ready = 1'b0;
    logic [31:0] if_addr = 32'h40, d_addr = '0, d_wdata = '0, mem_output = '0;
    logic [31:0] if_rdata, d_rdata, mem_address, mem_input;
    logic if_valid, d_valid, mem_enable, mem_r_w, pipe_stall, timeout_err;
    int errs = 0, checks = 0;

    mem_port_arbiter dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_valid(d_valid),
        .mem_enable(mem_enable), .mem_r_w(mem_r_w), .mem_address(mem_address),
        .mem_input(mem_input), .mem_output(mem_output), .mem_ready(mem_ready),
        .pipe_stall(pipe_stall), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // in = {reset, if_req, d_req, d_we, mem_ready}; ex = {en, r_w, if_valid, d_valid, stall}
    typedef struct {
        logic [4:0]  in;
        logic [31:0] da, wd, mo;
        logic [4:0]  ex;
        logic [31:0] addr, minp, ird, drd;
    } vec_t;
    vec_t v[16];

    task automatic tie(input logic [31:0] exp_addr, input int n);
        if_req = 1'b1;
        d_req = 1'b1;
        tick();
        chk($sformatf("tie%0d en", n), 32'(mem_enable), 32'd1);
        chk($sformatf("tie%0d addr", n), mem_address, exp_addr);
        tick();
        chk($sformatf("tie%0d done", n), 32'(if_valid | d_valid), 32'd1);
        if_req = 1'b0;
        d_req = 1'b0;
        tick();
    endtask

    initial begin
        int busy;
        v[0]  = '{5'b01100, 32'h100, 32'h0, 32'h0, 5'b00001, 32'h0, 32'h0, 32'h0, 32'h0};
        v[1]  = '{5'b01100, 32'h100, 32'h0, 32'h0, 5'b00001, 32'h0, 32'h0, 32'h0, 32'h0};
        v[2]  = '{5'b11100, 32'h100, 32'h0, 32'h0, 5'b10001, 32'h100, 32'h0, 32'h0, 32'h0};
        v[3]  = '{5'b11101, 32'h100, 32'h0, 32'hCAFE0001, 5'b00011, 32'h0, 32'h0, 32'h0, 32'hCAFE0001};
        v[4]  = '{5'b11001, 32'h100, 32'h0, 32'hCAFE0001, 5'b10001, 32'h40, 32'h0, 32'h0, 32'hCAFE0001};
        v[5]  = '{5'b11001, 32'h100, 32'h0, 32'h11, 5'b00100, 32'h0, 32'h0, 32'h11, 32'hCAFE0001};
        v[6]  = '{5'b10001, 32'h100, 32'h0, 32'h11, 5'b00000, 32'h0, 32'h0, 32'h11, 32'hCAFE0001};
        v[7]  = '{5'b11001, 32'h100, 32'h0, 32'h13, 5'b10001, 32'h40, 32'h0, 32'h11, 32'hCAFE0001};
        v[8]  = '{5'b11001, 32'h100, 32'h0, 32'h13, 5'b00100, 32'h0, 32'h0, 32'h13, 32'hCAFE0001};
        v[9]  = '{5'b10001, 32'h100, 32'h0, 32'hFFFFFFFF, 5'b00000, 32'h0, 32'h0, 32'h13, 32'hCAFE0001};
        v[10] = '{5'b10110, 32'h80, 32'hDEADBEEF, 32'h0, 5'b11001, 32'h80, 32'hDEADBEEF, 32'h13, 32'hCAFE0001};
        v[11] = '{5'b10100, 32'h999, 32'h12345678, 32'h0, 5'b11001, 32'h80, 32'hDEADBEEF, 32'h13, 32'hCAFE0001};
        v[12] = '{5'b10100, 32'h999, 32'h12345678, 32'h0, 5'b11001, 32'h80, 32'hDEADBEEF, 32'h13, 32'hCAFE0001};
        v[13] = '{5'b10100, 32'h999, 32'h12345678, 32'h0, 5'b11001, 32'h80, 32'hDEADBEEF, 32'h13, 32'hCAFE0001};
        v[14] = '{5'b10101, 32'h999, 32'h12345678, 32'h55555555, 5'b00010, 32'h0, 32'h0, 32'h13, 32'hCAFE0001};
        v[15] = '{5'b10000, 32'h999, 32'h12345678, 32'h0, 5'b00000, 32'h0, 32'h0, 32'h13, 32'hCAFE0001};
        for (int i = 0; i < 16; i++) begin
            {reset, if_req, d_req, d_we, mem_ready} = v[i].in;
            d_addr = v[i].da;
            d_wdata = v[i].wd;
            mem_output = v[i].mo;
            tick();
            chk($sformatf("v%0d en", i), 32'(mem_enable), 32'(v[i].ex[4]));
            chk($sformatf("v%0d if_valid", i), 32'(if_valid), 32'(v[i].ex[2]));
            chk($sformatf("v%0d d_valid", i), 32'(d_valid), 32'(v[i].ex[1]));
            chk($sformatf("v%0d stall", i), 32'(pipe_stall), 32'(v[i].ex[0]));
            chk($sformatf("v%0d if_rdata", i), if_rdata, v[i].ird);
            chk($sformatf("v%0d d_rdata", i), d_rdata, v[i].drd);
            chk($sformatf("v%0d terr", i), 32'(timeout_err), 32'd0);
            if (v[i].ex[4] || !v[i].in[4]) begin
                chk($sformatf("v%0d r_w", i), 32'(mem_r_w), 32'(v[i].ex[3]));
                chk($sformatf("v%0d addr", i), mem_address, v[i].addr);
                chk($sformatf("v%0d minp", i), mem_input, v[i].minp);
            end
        end

        // both held: a just-served requester is masked, so grants alternate with 1-cycle gaps
        if_req = 1'b1;
        d_req = 1'b1;
        d_we = 1'b0;
        d_addr = 32'h100;
        mem_ready = 1'b1;
        mem_output = 32'hA5A5A5A5;
        for (int k = 0; k < 12; k++) begin
            tick();
            chk($sformatf("b2b%0d en", k), 32'(mem_enable), 32'(k % 2 == 0));
            if (k % 2 == 0)
                chk($sformatf("b2b%0d addr", k), mem_address, ((k / 2) % 2 == 0) ? 32'h100 : 32'h40);
        end
        if_req = 1'b0;
        d_req = 1'b0;
        tick();

        // fresh ties from idle: fetch wins once it has lost twice
        tie(32'h100, 0);
        tie(32'h100, 1);
        tie(32'h40, 2);
        tie(32'h100, 3);
        chk("tie d_rdata", d_rdata, 32'hA5A5A5A5);

        // timeout: ready never comes
        d_req = 1'b1;
        mem_ready = 1'b0;
        busy = 0;
        for (int i = 0; i < 40 && !d_valid; i++) begin
            tick();
            if (mem_enable) busy++;
        end
        chk("to busy cycles", 32'(busy), 32'd15);
        chk("to d_valid", 32'(d_valid), 32'd1);
        chk("to en", 32'(mem_enable), 32'd0);
        chk("to d_rdata", d_rdata, 32'h0);
        chk("to terr", 32'(timeout_err), 32'd1);
        d_req = 1'b0;
        repeat (3) tick();
        chk("to terr sticky", 32'(timeout_err), 32'd1);

        // reset in the second wait cycle of a fetch
        if_req = 1'b1;
        tick();
        chk("rst busy", 32'(mem_enable), 32'd1);
        tick();
        reset = 1'b0;
        tick();
        chk("rst en", 32'(mem_enable), 32'd0);
        chk("rst if_valid", 32'(if_valid), 32'd0);
        chk("rst terr", 32'(timeout_err), 32'd0);
        chk("rst if_rdata", if_rdata, 32'h0);
        reset = 1'b1;
        mem_output = 32'h00C0FFEE;
        tick();
        chk("rst regrant en", 32'(mem_enable), 32'd1);
        chk("rst regrant addr", mem_address, 32'h40);
        chk("rst regrant if_valid", 32'(if_valid), 32'd0);
        mem_ready = 1'b1;
        tick();
        chk("rst fetch valid", 32'(if_valid), 32'd1);
        chk("rst fetch data", if_rdata, 32'h00C0FFEE);
        if_req = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
